// File: rtl/imem_uart_loader.sv
// ---------------------------------------------------------------------------
// imem_uart_loader
//   Fills the MIPS instruction memory from a UART byte stream. Bytes arrive
//   8N1, LSB first. Every four bytes form one big-endian 32-bit word, and the
//   words are written to consecutive word addresses starting at 0. The core
//   is held in reset until loading is done. Loading ends when the terminator
//   word 32'hFFFFFFFF arrives or when the memory is full.
//
// Ports
//   Clk        system clock, rising edge
//   Rst        synchronous active-high reset
//   Rx         asynchronous UART line, idle high
//   WrEn       one-cycle instruction-memory write strobe
//   WrAddr     word address of the write (holds its value between writes)
//   WrData     instruction word of the write (holds its value between writes)
//   CpuHold    reset request to the core, high until loading is done
//   Done       loading complete, sticky until Rst
//   FrameErr   sticky: at least one byte had a bad stop bit
//   WordCount  number of words written so far
// ---------------------------------------------------------------------------
module imem_uart_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 6
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Rx,
  output logic              WrEn,
  output logic [ADDR_W-1:0] WrAddr,
  output logic [31:0]       WrData,
  output logic              CpuHold,
  output logic              Done,
  output logic              FrameErr,
  output logic [ADDR_W:0]   WordCount
);

  localparam int TMR_W = $clog2(CLKS_PER_BIT);
  localparam logic [TMR_W-1:0] FULL_T   = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [TMR_W-1:0] HALF_T   = TMR_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [ADDR_W:0]  CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]  CNT_LAST = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [31:0]      TERM     = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_rx_meta;
  logic              r_rx_sync;
  logic [TMR_W-1:0]  r_timer;
  logic [2:0]        r_bitcnt;
  logic [7:0]        r_shift;
  logic [31:0]       r_word;
  logic [1:0]        r_bytecnt;
  logic              r_wren;
  logic [ADDR_W-1:0] r_wraddr;
  logic [31:0]       r_wrdata;
  logic              r_done;
  logic              r_hold;
  logic              r_ferr;
  logic [ADDR_W:0]   r_count;

  logic              w_rx;
  logic              w_tick_half;
  logic              w_tick_full;
  logic              w_clr_timer;
  logic              w_shift_bit;
  logic              w_stop_sample;
  logic              w_accept;
  logic              w_bad_stop;
  logic              w_word_done;
  logic [31:0]       w_word_nxt;

  // Two-flop synchronizer; reset to the idle level so reset never looks like a start bit
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= Rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  assign w_rx        = r_rx_sync;
  assign w_tick_half = (r_timer == HALF_T);
  assign w_tick_full = (r_timer == FULL_T);

  // RX FSM: state register
  always_ff @(posedge Clk) begin
    if (Rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // RX FSM: next state. Once loading is done, no new byte is started.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (!w_rx && !r_done)           w_state_nxt = S_START;
      S_START: if (w_tick_half)                w_state_nxt = w_rx ? S_IDLE : S_DATA;
      S_DATA:  if (w_tick_full && &r_bitcnt)   w_state_nxt = S_STOP;
      S_STOP:  if (w_tick_full)                w_state_nxt = S_IDLE;
      default:                                 w_state_nxt = S_IDLE;
    endcase
  end

  // RX FSM: outputs. The timer is held at zero while idle, so it is already
  // clear on the first START cycle.
  always_comb begin
    w_clr_timer   = 1'b0;
    w_shift_bit   = 1'b0;
    w_stop_sample = 1'b0;
    case (r_state)
      S_IDLE:  w_clr_timer = 1'b1;
      S_START: w_clr_timer = w_tick_half;
      S_DATA: begin
        w_shift_bit = w_tick_full;
        w_clr_timer = w_tick_full;
      end
      S_STOP:  w_stop_sample = w_tick_full;
      default: w_clr_timer = 1'b1;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_timer  <= '0;
      r_bitcnt <= '0;
    end else begin
      r_timer <= w_clr_timer ? '0 : r_timer + TMR_ONE;
      if (r_state == S_START) r_bitcnt <= '0;
      else if (w_shift_bit)   r_bitcnt <= r_bitcnt + 3'd1;
    end
  end

  // LSB-first data shifter; contents are meaningless until eight bits are in
  always_ff @(posedge Clk) begin
    if (w_shift_bit) r_shift <= {w_rx, r_shift[7:1]};
  end

  assign w_accept    = w_stop_sample && w_rx && !r_done;
  assign w_bad_stop  = w_stop_sample && !w_rx && !r_done;
  assign w_word_nxt  = {r_word[23:0], r_shift};
  assign w_word_done = w_accept && (r_bytecnt == 2'd3);

  // The first byte of a word ends up in the MSB; r_bytecnt tracks the
  // alignment, so r_word needs no reset of its own.
  always_ff @(posedge Clk) begin
    if (w_accept) r_word <= w_word_nxt;
  end

  // Write path and completion control
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_bytecnt <= '0;
      r_wren    <= 1'b0;
      r_wraddr  <= '0;
      r_wrdata  <= '0;
      r_done    <= 1'b0;
      r_hold    <= 1'b1;
      r_ferr    <= 1'b0;
      r_count   <= '0;
    end else begin
      r_wren <= 1'b0;
      if (w_accept)   r_bytecnt <= r_bytecnt + 2'd1;
      if (w_bad_stop) r_ferr    <= 1'b1;
      if (w_word_done) begin
        if (w_word_nxt == TERM) begin
          r_done <= 1'b1;
          r_hold <= 1'b0;
        end else begin
          r_wren   <= 1'b1;
          r_wraddr <= r_count[ADDR_W-1:0];
          r_wrdata <= w_word_nxt;
        end
      end
      // The count advances as the strobe drops; the last slot finishes loading
      if (r_wren) begin
        r_count <= r_count + CNT_ONE;
        if (r_count == CNT_LAST) begin
          r_done <= 1'b1;
          r_hold <= 1'b0;
        end
      end
    end
  end

  assign WrEn      = r_wren;
  assign WrAddr    = r_wraddr;
  assign WrData    = r_wrdata;
  assign CpuHold   = r_hold;
  assign Done      = r_done;
  assign FrameErr  = r_ferr;
  assign WordCount = r_count;

endmodule

// File: tb/tb_imem_uart_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_uart_loader
//   Two loader instances share clock and reset: a 64-word memory and a
//   4-word memory (for the full-memory case). A word-level model predicts
//   the write sequence, the completion flag and the frame-error flag from
//   the bytes sent. One negedge process checks every write against the
//   model and the output invariants on every cycle.
// ---------------------------------------------------------------------------
module tb_imem_uart_loader;

  localparam int CPB = 4;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        rx6 = 1'b1;
  logic        rx2 = 1'b1;

  logic        we6, we2;
  logic [5:0]  wa6;
  logic [1:0]  wa2;
  logic [31:0] wd6, wd2;
  logic        hold6, hold2, done6, done2, ferr6, ferr2;
  logic [6:0]  wc6;
  logic [2:0]  wc2;

  always #5 Clk = ~Clk;

  imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(6)) u_dut6 (
    .Clk(Clk), .Rst(Rst), .Rx(rx6), .WrEn(we6), .WrAddr(wa6), .WrData(wd6),
    .CpuHold(hold6), .Done(done6), .FrameErr(ferr6), .WordCount(wc6));

  imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(2)) u_dut2 (
    .Clk(Clk), .Rst(Rst), .Rx(rx2), .WrEn(we2), .WrAddr(wa2), .WrData(wd2),
    .CpuHold(hold2), .Done(done2), .FrameErr(ferr2), .WordCount(wc2));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          inst;
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          m_cap[2] = '{64, 4};
  logic [31:0] m_word[2];
  int          m_nbytes[2];
  int          m_count[2];
  bit          m_done[2];
  bit          m_ferr[2];
  int          h_addr[2];
  logic [31:0] h_data[2];
  bit          p_we[2];
  bit          p_done[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // ---------------- model ----------------
  task automatic model_clear();
    exp_q.delete();
    for (int k = 0; k < 2; k++) begin
      m_word[k] = '0; m_nbytes[k] = 0; m_count[k] = 0;
      m_done[k] = 0;  m_ferr[k] = 0;
      h_addr[k] = 0;  h_data[k] = '0;
    end
  endtask

  task automatic model_byte(input int k, input logic [7:0] b, input bit stop_ok);
    wr_t e;
    if (m_done[k]) return;
    if (!stop_ok) begin
      m_ferr[k] = 1;
      return;
    end
    m_word[k] = {m_word[k][23:0], b};
    m_nbytes[k]++;
    if (m_nbytes[k] == 4) begin
      m_nbytes[k] = 0;
      if (m_word[k] == 32'hFFFF_FFFF) m_done[k] = 1;
      else begin
        e.inst = k; e.addr = m_count[k] % m_cap[k]; e.data = m_word[k];
        exp_q.push_back(e);
        m_count[k]++;
        if (m_count[k] == m_cap[k]) m_done[k] = 1;
      end
    end
  endtask

  // ---------------- per-cycle compare ----------------
  logic        c_we, c_dn, c_hold;
  int          c_a;
  logic [31:0] c_d;
  wr_t         c_e;

  always @(negedge Clk) begin
    if (Rst) begin
      p_we   = '{0, 0};
      p_done = '{0, 0};
    end else begin
      for (int k = 0; k < 2; k++) begin
        c_we   = (k == 0) ? we6   : we2;
        c_dn   = (k == 0) ? done6 : done2;
        c_hold = (k == 0) ? hold6 : hold2;
        c_a    = (k == 0) ? int'(wa6) : int'(wa2);
        c_d    = (k == 0) ? wd6 : wd2;
        chk("cpuhold_vs_done", c_hold, !c_dn);
        if (p_done[k]) chk("done_sticky", c_dn, 1'b1);
        if (c_we) begin
          chk("wren_one_cycle", p_we[k], 1'b0);
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write inst=%0d addr=%0h data=%0h required=no_write", k, c_a, c_d);
          end else begin
            c_e = exp_q.pop_front();
            chk("write_inst", k, c_e.inst);
            chk("write_addr", c_a, c_e.addr);
            chk("write_data", c_d, c_e.data);
            h_addr[k] = c_e.addr;
            h_data[k] = c_e.data;
          end
        end else begin
          chk("addr_hold", c_a, h_addr[k]);
          chk("data_hold", c_d, h_data[k]);
        end
        p_we[k]   = c_we;
        p_done[k] = c_dn;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_rx(input int k, input logic v);
    if (k == 0) rx6 = v; else rx2 = v;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic send_byte(input int k, input logic [7:0] b, input bit stop_ok);
    set_rx(k, 1'b0);
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      set_rx(k, b[i]);
      wait_cyc(CPB);
    end
    model_byte(k, b, stop_ok);
    set_rx(k, stop_ok);
    wait_cyc(CPB);
    set_rx(k, 1'b1);
    wait_cyc(stop_ok ? $urandom_range(0, 3) : 2 * CPB);
  endtask

  task automatic send_word(input int k, input logic [31:0] w);
    send_byte(k, w[31:24], 1);
    send_byte(k, w[23:16], 1);
    send_byte(k, w[15:8],  1);
    send_byte(k, w[7:0],   1);
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    chk("rst_wren6",  we6,   1'b0);
    chk("rst_addr6",  wa6,   6'd0);
    chk("rst_data6",  wd6,   32'd0);
    chk("rst_done6",  done6, 1'b0);
    chk("rst_ferr6",  ferr6, 1'b0);
    chk("rst_wc6",    wc6,   7'd0);
    chk("rst_hold6",  hold6, 1'b1);
    chk("rst_done2",  done2, 1'b0);
    chk("rst_wc2",    wc2,   3'd0);
    chk("rst_hold2",  hold2, 1'b1);
    model_clear();
    Rst = 1'b0;
    wait_cyc(2);
  endtask

  task automatic check_state(input int k);
    int wc;
    logic dn, fe, hd;
    wait_cyc(3 * CPB);
    wc = (k == 0) ? int'(wc6) : int'(wc2);
    dn = (k == 0) ? done6 : done2;
    fe = (k == 0) ? ferr6 : ferr2;
    hd = (k == 0) ? hold6 : hold2;
    chk("word_count", wc, m_count[k]);
    chk("done", dn, m_done[k]);
    chk("frame_err", fe, m_ferr[k]);
    chk("cpu_hold", hd, !m_done[k]);
    chk("writes_drained", exp_q.size(), 0);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == 32'hFFFF_FFFF) w = 32'h0123_4567;
    return w;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    model_clear();
    wait_cyc(3);
    do_reset();

    // Single word
    send_word(0, 32'h2002_0005);
    check_state(0);
    chk("t1_addr_lit", h_addr[0], 0);
    chk("t1_data_lit", wd6, 32'h2002_0005);
    chk("t1_wc_lit", wc6, 7'd1);
    chk("t1_hold_lit", hold6, 1'b1);

    // Short glitch is not a byte
    set_rx(0, 1'b0);
    wait_cyc(1);
    set_rx(0, 1'b1);
    wait_cyc(3 * CPB);
    send_word(0, 32'h0064_202A);
    check_state(0);
    chk("t3_addr_lit", wa6, 6'd1);
    chk("t3_data_lit", wd6, 32'h0064_202A);

    // Bad stop bit drops the byte
    send_byte(0, 8'h8C, 0);
    send_word(0, 32'h8C02_0028);
    check_state(0);
    chk("t4_ferr_lit", ferr6, 1'b1);
    chk("t4_data_lit", wd6, 32'h8C02_0028);
    chk("t4_addr_lit", wa6, 6'd2);

    // Terminator ends loading
    do_reset();
    send_word(0, 32'h2002_0005);
    send_word(0, 32'h2003_000C);
    send_word(0, 32'h2067_FFF7);
    send_word(0, 32'hFFFF_FFFF);
    check_state(0);
    chk("t2_wc_lit", wc6, 7'd3);
    chk("t2_done_lit", done6, 1'b1);
    chk("t2_hold_lit", hold6, 1'b0);
    // After Done: traffic and framing errors are ignored
    send_byte(0, 8'h55, 0);
    send_word(0, 32'h1234_5678);
    check_state(0);
    chk("t2_ferr_after_done", ferr6, 1'b0);

    // Reset mid-word discards the partial word
    do_reset();
    send_byte(0, 8'hAC, 1);
    send_byte(0, 8'h02, 1);
    do_reset();
    send_word(0, 32'h0800_0016);
    check_state(0);
    chk("t6_addr_lit", wa6, 6'd0);
    chk("t6_data_lit", wd6, 32'h0800_0016);

    // Full memory on the 4-word instance
    do_reset();
    for (int i = 0; i < 5; i++) send_word(1, rand_word());
    check_state(1);
    chk("t5_wc_lit", wc2, 3'd4);
    chk("t5_done_lit", done2, 1'b1);
    send_byte(1, 8'h00, 0);
    check_state(1);
    chk("t5_ferr_lit", ferr2, 1'b0);

    // Randomized program with occasional bad bytes, then terminator
    do_reset();
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 3) == 0) send_byte(0, 8'($urandom), 0);
      send_word(0, rand_word());
    end
    check_state(0);
    send_word(0, 32'hFFFF_FFFF);
    check_state(0);
    chk("rnd_done_lit", done6, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
